// File: rtl/move_recorder_if.sv
// Button inputs and packed move-sequence outputs of the move recorder.
interface move_recorder_if #(
  parameter int MAX_MOVES = 32
);
  logic [3:0]             btn_dir;
  logic                   btn_undo;
  logic                   btn_done;
  logic [2*MAX_MOVES-1:0] ord;
  logic [63:0]            cnt;
  logic                   comp;
  logic                   full;
  logic                   move_valid;
  logic [1:0]             move_code;

  modport master (
    output btn_dir, btn_undo, btn_done,
    input  ord, cnt, comp, full,
    input  move_valid, move_code
  );

  modport slave (
    input  btn_dir, btn_undo, btn_done,
    output ord, cnt, comp, full,
    output move_valid, move_code
  );
endinterface

// File: rtl/move_recorder.sv
// Debounces the push-buttons and records a 2-bit-per-move sequence
// with undo and commit for the display/browse block.
module move_recorder #(
  parameter int TICK_DIV  = 12,
  parameter int MAX_MOVES = 32
) (
  input logic            clk,
  input logic            rst,
  move_recorder_if.slave bus
);

  localparam int CW = $clog2(MAX_MOVES + 1);
  localparam int OW = 2 * MAX_MOVES;
  localparam int IW = $clog2(OW);

  typedef enum logic { REC, DONE } state_t;

  state_t              state;
  logic [TICK_DIV-1:0] tcnt;
  logic [5:0]          s;
  logic [5:0]          st;
  logic [OW-1:0]       ord_q;
  logic [CW-1:0]       count;
  logic                mv_valid;
  logic [1:0]          mv_code;

  logic                tick;
  logic [5:0]          raw;
  logic [5:0]          ev;
  logic [1:0]          dir_code;
  logic [IW-1:0]       wr_idx;
  logic [IW-1:0]       un_idx;
  logic                is_full;

  // raw bit order: done, undo, up, down, left, right
  assign raw     = {bus.btn_done, bus.btn_undo, bus.btn_dir};
  assign tick    = (tcnt == '0);
  assign ev      = raw & s & ~st;
  assign is_full = (count == CW'(MAX_MOVES));
  assign wr_idx  = IW'(2 * count);
  assign un_idx  = IW'(2 * (count - CW'(1)));

  always_comb begin
    dir_code = 2'd3;
    if (ev[3])      dir_code = 2'd0;
    else if (ev[2]) dir_code = 2'd1;
    else if (ev[1]) dir_code = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REC;
      tcnt     <= '0;
      s        <= '0;
      st       <= '0;
      ord_q    <= '0;
      count    <= '0;
      mv_valid <= 1'b0;
      mv_code  <= 2'd0;
    end else begin
      tcnt     <= tcnt + 1'b1;
      mv_valid <= 1'b0;
      if (tick) begin
        s  <= raw;
        // stable value follows raw only when two samples agree
        st <= (raw & ~(raw ^ s)) | (st & (raw ^ s));
        priority case (1'b1)
          ev[5]: begin
            if (state == REC) begin
              if (count != '0) state <= DONE;
            end else begin
              ord_q <= '0;
              count <= '0;
              state <= REC;
            end
          end
          ev[4]: begin
            if (state == DONE) begin
              state <= REC;
            end else if (count != '0) begin
              ord_q[un_idx +: 2] <= 2'd0;
              count              <= count - CW'(1);
            end
          end
          (|ev[3:0]): begin
            if (state == REC && !is_full) begin
              ord_q[wr_idx +: 2] <= dir_code;
              count              <= count + CW'(1);
              mv_valid           <= 1'b1;
              mv_code            <= dir_code;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ord        = ord_q;
  assign bus.cnt        = 64'(count);
  assign bus.comp       = (state == DONE);
  assign bus.full       = is_full;
  assign bus.move_valid = mv_valid;
  assign bus.move_code  = mv_code;

endmodule

// File: tb/tb_move_recorder.sv
// Directed self-checking bench for move_recorder with a 4-cycle
// button sample tick.
module tb_move_recorder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  move_recorder_if #(.MAX_MOVES(32)) bus ();

  move_recorder #(
    .TICK_DIV (2),
    .MAX_MOVES(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.move_valid === 1'b1) pulses++;

  // mask bits: done, undo, up, down, left, right
  task automatic drive(input logic [5:0] m, input int n);
    @(negedge clk);
    bus.btn_done = m[5];
    bus.btn_undo = m[4];
    bus.btn_dir  = m[3:0];
    repeat (n - 1) @(negedge clk);
  endtask

  // any 8 consecutive cycles hold exactly two ticks
  task automatic press(input logic [5:0] m);
    drive(m, 8);
    drive(6'b0, 8);
  endtask

  function automatic logic [5:0] dir_mask(input int code);
    logic [3:0] d;
    d = 4'b1000 >> code;
    return {2'b00, d};
  endfunction

  task automatic test_reset;
    bus.btn_dir  = 4'b0;
    bus.btn_undo = 1'b0;
    bus.btn_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ord !== 64'd0 || bus.cnt !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: ord=%h cnt=%0d expected 0/0",
               bus.ord, bus.cnt);
    end
    checks++;
    if ({bus.comp, bus.full, bus.move_valid, bus.move_code} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: comp=%b full=%b mv=%b code=%0d expected 0",
               bus.comp, bus.full, bus.move_valid, bus.move_code);
    end
  endtask

  task automatic test_hold;
    int p0;
    p0 = pulses;
    drive(6'b001000, 12);
    drive(6'b0, 8);
    checks++;
    if (pulses - p0 !== 1 || bus.move_code !== 2'd0) begin
      errors++;
      $display("FAIL hold_up: pulses=%0d code=%0d expected 1/0",
               pulses - p0, bus.move_code);
    end
    checks++;
    if (bus.cnt !== 64'd1 || bus.ord !== 64'd0) begin
      errors++;
      $display("FAIL hold_up_state: cnt=%0d ord=%h expected 1/0",
               bus.cnt, bus.ord);
    end
  endtask

  task automatic test_sequence;
    int p0;
    p0 = pulses;
    press(6'b000001);
    press(6'b000010);
    press(6'b000100);
    checks++;
    if (bus.cnt !== 64'd4 || bus.ord[7:0] !== 8'b01_10_11_00
        || pulses - p0 !== 3) begin
      errors++;
      $display("FAIL seq4: cnt=%0d ord=%b pulses=%0d expected 4/01101100/3",
               bus.cnt, bus.ord[7:0], pulses - p0);
    end
    checks++;
    if (bus.move_code !== 2'd1) begin
      errors++;
      $display("FAIL seq_code: code=%0d expected 1", bus.move_code);
    end
    press(6'b010000);
    checks++;
    if (bus.cnt !== 64'd3 || bus.ord !== 64'b10_11_00) begin
      errors++;
      $display("FAIL undo: cnt=%0d ord=%h expected 3/2c", bus.cnt, bus.ord);
    end
    checks++;
    if (bus.move_code !== 2'd1) begin
      errors++;
      $display("FAIL code_hold: code=%0d expected 1", bus.move_code);
    end
  endtask

  task automatic test_empty;
    int p0;
    repeat (3) press(6'b010000);
    checks++;
    if (bus.cnt !== 64'd0 || bus.ord !== 64'd0) begin
      errors++;
      $display("FAIL undo_all: cnt=%0d ord=%h expected 0/0",
               bus.cnt, bus.ord);
    end
    press(6'b010000);
    press(6'b100000);
    checks++;
    if (bus.cnt !== 64'd0 || bus.comp !== 1'b0) begin
      errors++;
      $display("FAIL empty_ops: cnt=%0d comp=%b expected 0/0",
               bus.cnt, bus.comp);
    end
    p0 = pulses;
    drive(6'b001000, 4);
    drive(6'b0, 8);
    checks++;
    if (bus.cnt !== 64'd0 || pulses !== p0) begin
      errors++;
      $display("FAIL glitch: cnt=%0d pulses=%0d expected 0/0",
               bus.cnt, pulses - p0);
    end
  endtask

  task automatic test_priority;
    press(6'b001010);
    checks++;
    if (bus.cnt !== 64'd1 || bus.move_code !== 2'd0 || bus.ord !== 64'd0) begin
      errors++;
      $display("FAIL up_left: cnt=%0d code=%0d ord=%h expected 1/0/0",
               bus.cnt, bus.move_code, bus.ord);
    end
    press(6'b000001);
    press(6'b110000);
    checks++;
    if (bus.comp !== 1'b1 || bus.cnt !== 64'd2 || bus.ord !== 64'b11_00) begin
      errors++;
      $display("FAIL done_undo: comp=%b cnt=%0d ord=%h expected 1/2/c",
               bus.comp, bus.cnt, bus.ord);
    end
    press(6'b100000);
    checks++;
    if (bus.comp !== 1'b0 || bus.cnt !== 64'd0 || bus.ord !== 64'd0) begin
      errors++;
      $display("FAIL clear: comp=%b cnt=%0d ord=%h expected 0/0/0",
               bus.comp, bus.cnt, bus.ord);
    end
  endtask

  task automatic test_fill;
    logic [63:0] exp_ord;
    int p0;
    exp_ord = '0;
    for (int k = 0; k < 32; k++) begin
      exp_ord[2*k +: 2] = 2'((k * 3 + 1) % 4);
      press(dir_mask((k * 3 + 1) % 4));
      if (k == 30) begin
        checks++;
        if (bus.full !== 1'b0 || bus.cnt !== 64'd31) begin
          errors++;
          $display("FAIL not_full: full=%b cnt=%0d expected 0/31",
                   bus.full, bus.cnt);
        end
      end
    end
    checks++;
    if (bus.full !== 1'b1 || bus.cnt !== 64'd32 || bus.ord !== exp_ord) begin
      errors++;
      $display("FAIL fill: full=%b cnt=%0d ord=%h expected 1/32/%h",
               bus.full, bus.cnt, bus.ord, exp_ord);
    end
    p0 = pulses;
    press(6'b000001);
    checks++;
    if (pulses !== p0 || bus.cnt !== 64'd32 || bus.ord !== exp_ord) begin
      errors++;
      $display("FAIL overflow: pulses=%0d cnt=%0d ord=%h expected 0/32/%h",
               pulses - p0, bus.cnt, bus.ord, exp_ord);
    end
    press(6'b100000);
    press(6'b001000);
    checks++;
    if (bus.comp !== 1'b1 || pulses !== p0 || bus.ord !== exp_ord) begin
      errors++;
      $display("FAIL done_dir: comp=%b pulses=%0d expected 1/0",
               bus.comp, pulses - p0);
    end
    press(6'b010000);
    checks++;
    if (bus.comp !== 1'b0 || bus.cnt !== 64'd32 || bus.ord !== exp_ord) begin
      errors++;
      $display("FAIL resume: comp=%b cnt=%0d expected 0/32",
               bus.comp, bus.cnt);
    end
    press(6'b100000);
    press(6'b100000);
    checks++;
    if (bus.comp !== 1'b0 || bus.cnt !== 64'd0 || bus.ord !== 64'd0
        || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL done_twice: comp=%b cnt=%0d ord=%h full=%b expected 0/0/0/0",
               bus.comp, bus.cnt, bus.ord, bus.full);
    end
  endtask

  task automatic test_reset_mid;
    repeat (5) press(6'b000100);
    press(6'b100000);
    checks++;
    if (bus.comp !== 1'b1 || bus.cnt !== 64'd5 || bus.ord !== 64'h155) begin
      errors++;
      $display("FAIL pre_rst: comp=%b cnt=%0d ord=%h expected 1/5/155",
               bus.comp, bus.cnt, bus.ord);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.comp !== 1'b0 || bus.cnt !== 64'd0 || bus.ord !== 64'd0
        || bus.full !== 1'b0 || bus.move_valid !== 1'b0
        || bus.move_code !== 2'd0) begin
      errors++;
      $display("FAIL mid_rst: comp=%b cnt=%0d ord=%h code=%0d expected all 0",
               bus.comp, bus.cnt, bus.ord, bus.move_code);
    end
    @(negedge clk);
    rst = 1'b0;
    press(6'b000010);
    checks++;
    if (bus.cnt !== 64'd1 || bus.ord !== 64'd2 || bus.move_code !== 2'd2) begin
      errors++;
      $display("FAIL post_rst: cnt=%0d ord=%h code=%0d expected 1/2/2",
               bus.cnt, bus.ord, bus.move_code);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_sequence();
    test_empty();
    test_priority();
    test_fill();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_recorder.md
# move_recorder

Captures a user-entered move sequence from the board push-buttons and packs it into the 2-bit-per-move `ord` word and `cnt` count consumed by the 7-segment display/browse block. It is the producing end of the `comp`/`cnt`/`ord` interface. It debounces and edge-detects the buttons, supports undo and commit, and hands a committed sequence to the display side by raising `comp`.

## Interface
Parameters:
- TICK_DIV, 12: button sample period is 2^TICK_DIV cycles (12 = display scan rate).
- MAX_MOVES, 32: sequence capacity; `ord` holds 2*MAX_MOVES bits.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- btn_dir  in  4  raw direction buttons: [3]=up, [2]=down, [1]=left, [0]=right.
- btn_undo  in  1  raw undo button.
- btn_done  in  1  raw commit/clear button.
- ord  out  64  packed moves; move k at bits [2k+1:2k], def.h codes UP=0, DOWN=1, LEFT=2, RIGHT=3; unused slots 0.
- cnt  out  64  number of recorded moves, 0..MAX_MOVES, upper bits 0.
- comp  out  1  sequence committed (DONE state).
- full  out  1  cnt == MAX_MOVES.
- move_valid  out  1  one-cycle pulse when a move is appended.
- move_code  out  2  code of appended move, valid with move_valid, holds last value otherwise.

## Operation
- Tick: free-running TICK_DIV-bit counter; tick when counter == 0. Buttons are sampled only on tick cycles.
- Debounce per button (6 buttons): previous-sample reg `s`, stable reg `st`. On tick: `s`<=raw; if raw==`s` then `st`<=raw. Press event = raw & `s` & ~`st` (high on two consecutive ticks, stable was low). Holding produces one event; re-press requires two low ticks.
- One event acted on per tick, priority: done > undo > up > down > left > right. Lower-priority simultaneous events are discarded (their `st` still updates).
- States: REC (comp=0), DONE (comp=1).
- REC, direction event: if cnt < MAX_MOVES, write code to slot cnt, cnt+1, pulse move_valid with move_code; if full, ignored (no pulse, no change).
- REC, undo: if cnt > 0, clear slot cnt-1 to 0, cnt-1; at cnt 0 ignored.
- REC, done: if cnt > 0 go DONE; at cnt 0 ignored.
- DONE, direction: ignored. DONE, undo: go REC, contents kept (editing resumes). DONE, done: clear ord and cnt to 0, go REC.
- full is combinational from cnt but registered path only (cnt is a register).

## Timing
- Reset: ord=0, cnt=0, comp=0, full=0, move_valid=0, move_code=0, state REC, tick counter 0, all `s`/`st` 0.
- Event decided on tick cycle T; ord/cnt/comp/move_valid update at T+1 (registered, one-cycle latency). move_valid high exactly one cycle.
- Minimum press-to-effect: raw high before tick N and N+1, effect visible one cycle after tick N+1.
- Reset asserted mid-sequence clears everything on the next edge regardless of tick; a button held through reset release needs no re-press only if sampled low-then-high: since `st`=0 after reset, a held button fires once after two ticks.
- Wrap: cnt never exceeds MAX_MOVES or goes below 0; tick counter wraps freely.

## Test plan
- Use TICK_DIV=2 (tick every 4 cycles). Reset then hold up 3 ticks -> exactly one move_valid, move_code=0, cnt=1, ord=0.
- Press right, left, down sequentially (each 2 ticks high, 2 low) after up -> cnt=4, ord[7:0]=8'b01_10_11_00; undo -> cnt=3, ord[7:6]=0.
- Undo at cnt 0 and done at cnt 0 -> no change, comp stays 0; raw pulse high for one tick only -> no event.
- Press up and left on the same ticks -> only up recorded (cnt+1, code 0); press done+undo together at cnt 2 -> comp=1, cnt 2.
- Fill 32 moves -> full=1, cnt=32; 33rd direction -> no move_valid, ord unchanged; done -> comp=1; undo -> comp=0, cnt 32; done twice -> ord=0, cnt=0, comp=0.
- Assert rst with cnt=5, comp=1 -> next cycle all outputs 0, state REC.
